transpose_unit: RTL and testbench

//  - Transposes one small 8-bit integer matrix (up to 5x5) in the matrix calculator datapath.
//  - The input bus is the shared two-slot matrix bus; only slot 0 is the operand.
//  - Outputs the transposed matrix, its swapped dimensions, and a validity flag.
//  - Sits beside the add/multiply units and is selected by the top-level operation mux.

---
 rtl/matrix_pkg.sv | 23 ++
 rtl/transpose_core.sv | 36 +++
 rtl/transpose_unit.sv | 67 ++++++
 tb/tb_transpose_unit.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared matrix-bus constants and helpers for the matrix calculator datapath.
package matrix_pkg;

  localparam int unsigned DIM_MAX = 5;
  localparam int unsigned ELEM_W  = 8;
  localparam int unsigned DIM_W   = 3;
  localparam int unsigned SLOT_W  = DIM_MAX * DIM_MAX * ELEM_W;
  localparam int unsigned BUS_W   = 2 * SLOT_W;

  // Bit offset of element (r,c) in the given slot; rows use a fixed stride of DIM_MAX.
  function automatic int unsigned elem_idx(input int unsigned slot,
                                           input int unsigned r,
                                           input int unsigned c);
    return slot * SLOT_W + (r * DIM_MAX + c) * ELEM_W;
  endfunction

  function automatic logic dims_legal(input logic [DIM_W-1:0] m,
                                      input logic [DIM_W-1:0] n);
    return (m != '0) && (m <= DIM_W'(DIM_MAX)) &&
           (n != '0) && (n <= DIM_W'(DIM_MAX));
  endfunction

endpackage

// File: rtl/transpose_core.sv
// Combinational 5x5 transpose of one slot with dimension check and zero-masking.
module transpose_core
  import matrix_pkg::*;
(
  input  logic [DIM_W-1:0]  m_in,
  input  logic [DIM_W-1:0]  n_in,
  input  logic [SLOT_W-1:0] slot_in,
  output logic [DIM_W-1:0]  m_out,
  output logic [DIM_W-1:0]  n_out,
  output logic [SLOT_W-1:0] slot_out,
  output logic              valid
);

  logic legal;

  always_comb begin
    legal    = dims_legal(m_in, n_in);
    valid    = legal;
    m_out    = '0;
    n_out    = '0;
    slot_out = '0;
    if (legal) begin
      m_out = n_in;
      n_out = m_in;
      // Only the n_in x m_in result region is populated; input padding never leaks through.
      for (int unsigned i = 0; i < DIM_MAX; i++) begin
        for (int unsigned j = 0; j < DIM_MAX; j++) begin
          if ((DIM_W'(i) < n_in) && (DIM_W'(j) < m_in)) begin
            slot_out[elem_idx(0, i, j) +: ELEM_W] = slot_in[elem_idx(0, j, i) +: ELEM_W];
          end
        end
      end
    end
  end

endmodule

// File: rtl/transpose_unit.sv
// Matrix transpose unit: core remap, reset gating and optional output register.
// Define TRANSPOSE_REG_OUT_EN to register all outputs (one-cycle latency).
module transpose_unit
  import matrix_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [DIM_W-1:0]  m_in,
  input  logic [DIM_W-1:0]  n_in,
  input  logic [BUS_W-1:0]  matrices_in,
  output logic [DIM_W-1:0]  m_out,
  output logic [DIM_W-1:0]  n_out,
  output logic [BUS_W-1:0]  matrices_out,
  output logic              valid
);

  logic [DIM_W-1:0]  core_m;
  logic [DIM_W-1:0]  core_n;
  logic [SLOT_W-1:0] core_slot;
  logic              core_valid;

  transpose_core u_core (
    .m_in     (m_in),
    .n_in     (n_in),
    .slot_in  (matrices_in[SLOT_W-1:0]),
    .m_out    (core_m),
    .n_out    (core_n),
    .slot_out (core_slot),
    .valid    (core_valid)
  );

`ifdef TRANSPOSE_REG_OUT_EN
  logic unused_slot1;
  assign unused_slot1 = ^matrices_in[BUS_W-1:SLOT_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_out        <= '0;
      n_out        <= '0;
      matrices_out <= '0;
      valid        <= 1'b0;
    end else begin
      m_out        <= core_m;
      n_out        <= core_n;
      matrices_out <= {{SLOT_W{1'b0}}, core_slot};
      valid        <= core_valid;
    end
  end
`else
  logic unused_inputs;
  assign unused_inputs = clk ^ (^matrices_in[BUS_W-1:SLOT_W]);

  always_comb begin
    m_out        = '0;
    n_out        = '0;
    matrices_out = '0;
    valid        = 1'b0;
    if (!reset) begin
      m_out        = core_m;
      n_out        = core_n;
      matrices_out = {{SLOT_W{1'b0}}, core_slot};
      valid        = core_valid;
    end
  end
`endif

endmodule

// File: tb/tb_transpose_unit.sv
// Table-driven self-checking bench for transpose_unit.
module tb_transpose_unit;

  logic         clk;
  logic         reset;
  logic [2:0]   m_in;
  logic [2:0]   n_in;
  logic [399:0] matrices_in;
  logic [2:0]   m_out;
  logic [2:0]   n_out;
  logic [399:0] matrices_out;
  logic         valid;

  int n_vec = 0;
  int n_err = 0;

  transpose_unit dut (
    .clk          (clk),
    .reset        (reset),
    .m_in         (m_in),
    .n_in         (n_in),
    .matrices_in  (matrices_in),
    .m_out        (m_out),
    .n_out        (n_out),
    .matrices_out (matrices_out),
    .valid        (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   m;
    logic [2:0]   n;
    logic [399:0] bus;
    logic [2:0]   em;
    logic [2:0]   en;
    logic         ev;
    logic [399:0] eout;
  } vec_t;

  localparam int NV = 9;
  vec_t vt[NV];

  function automatic logic [399:0] put(input logic [399:0] b, input int r, input int c,
                                       input logic [7:0] val);
    logic [399:0] t;
    t = b;
    t[(r * 5 + c) * 8 +: 8] = val;
    return t;
  endfunction

  task automatic cmp(input string nm, input logic [399:0] act, input logic [399:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [2:0] em, input logic [2:0] en,
                           input logic ev, input logic [399:0] eout);
    cmp({tag, ".valid"}, {399'b0, valid}, {399'b0, ev});
    cmp({tag, ".m_out"}, {397'b0, m_out}, {397'b0, em});
    cmp({tag, ".n_out"}, {397'b0, n_out}, {397'b0, en});
    cmp({tag, ".data"}, matrices_out, eout);
  endtask

  // Outputs are sampled 1ns after the inputs (combinational) or after the next edge.
  task automatic settle();
`ifdef TRANSPOSE_REG_OUT_EN
    @(posedge clk);
`endif
    #1;
  endtask

  initial begin
    logic [399:0] b;
    logic [399:0] e;

    // 1x3 [1 2 3] -> 3x1
    b = '0; b = put(b, 0, 0, 8'd1); b = put(b, 0, 1, 8'd2); b = put(b, 0, 2, 8'd3);
    e = '0; e = put(e, 0, 0, 8'd1); e = put(e, 1, 0, 8'd2); e = put(e, 2, 0, 8'd3);
    vt[0] = '{3'd1, 3'd3, b, 3'd3, 3'd1, 1'b1, e};

    // 2x3 with slot1 all ones -> 3x2, upper half zero
    b = '0; b[399:200] = '1;
    b = put(b, 0, 0, 8'd1); b = put(b, 0, 1, 8'd2); b = put(b, 0, 2, 8'd3);
    b = put(b, 1, 0, 8'd4); b = put(b, 1, 1, 8'd5); b = put(b, 1, 2, 8'd6);
    e = '0;
    e = put(e, 0, 0, 8'd1); e = put(e, 0, 1, 8'd4);
    e = put(e, 1, 0, 8'd2); e = put(e, 1, 1, 8'd5);
    e = put(e, 2, 0, 8'd3); e = put(e, 2, 1, 8'd6);
    vt[1] = '{3'd2, 3'd3, b, 3'd3, 3'd2, 1'b1, e};

    // 5x5 e(r,c)=r*5+c -> out(i,j)=j*5+i
    b = '0; e = '0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) begin
        b = put(b, r, c, 8'(r * 5 + c));
        e = put(e, r, c, 8'(c * 5 + r));
      end
    vt[2] = '{3'd5, 3'd5, b, 3'd5, 3'd5, 1'b1, e};

    // 1x1 identity
    b = '0; b = put(b, 0, 0, 8'hAB);
    vt[3] = '{3'd1, 3'd1, b, 3'd1, 3'd1, 1'b1, b};

    // illegal dims: m=0, n=6, both 7 -> all zero
    b = '1;
    vt[4] = '{3'd0, 3'd3, b, 3'd0, 3'd0, 1'b0, '0};
    vt[5] = '{3'd2, 3'd6, b, 3'd0, 3'd0, 1'b0, '0};
    vt[6] = '{3'd7, 3'd7, b, 3'd0, 3'd0, 1'b0, '0};

    // 2x2 with garbage padding at (0,4) and (4,4)
    b = '0; b = put(b, 0, 0, 8'd1); b = put(b, 0, 1, 8'd2);
    b = put(b, 1, 0, 8'd3); b = put(b, 1, 1, 8'd4);
    b = put(b, 0, 4, 8'h5A); b = put(b, 4, 4, 8'h77);
    e = '0; e = put(e, 0, 0, 8'd1); e = put(e, 0, 1, 8'd3);
    e = put(e, 1, 0, 8'd2); e = put(e, 1, 1, 8'd4);
    vt[7] = '{3'd2, 3'd2, b, 3'd2, 3'd2, 1'b1, e};

    // 5x1 column -> 1x5 row
    b = '0; e = '0;
    for (int r = 0; r < 5; r++) begin
      b = put(b, r, 0, 8'(9 - r));
      e = put(e, 0, r, 8'(9 - r));
    end
    vt[8] = '{3'd5, 3'd1, b, 3'd1, 3'd5, 1'b1, e};

    // Reset asserted with legal inputs: outputs forced to zero at once
    reset = 1'b1;
    m_in = vt[2].m; n_in = vt[2].n; matrices_in = vt[2].bus;
    #1;
    check_all("reset_init", 3'd0, 3'd0, 1'b0, '0);
    @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < NV; k++) begin
      @(negedge clk);
      m_in = vt[k].m; n_in = vt[k].n; matrices_in = vt[k].bus;
      settle();
      check_all($sformatf("vec%0d", k), vt[k].em, vt[k].en, vt[k].ev, vt[k].eout);
    end

    // Mid-operation reset drops everything immediately, then recovers
    @(negedge clk);
    m_in = vt[1].m; n_in = vt[1].n; matrices_in = vt[1].bus;
    settle();
    check_all("pre_reset", vt[1].em, vt[1].en, vt[1].ev, vt[1].eout);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all("mid_reset", 3'd0, 3'd0, 1'b0, '0);
    @(negedge clk);
    reset = 1'b0;
`ifdef TRANSPOSE_REG_OUT_EN
    #1;
    check_all("post_reset_hold", 3'd0, 3'd0, 1'b0, '0);
`endif
    settle();
    check_all("post_reset", vt[1].em, vt[1].en, vt[1].ev, vt[1].eout);

`ifdef TRANSPOSE_REG_OUT_EN
    // Registered build: new inputs are not visible until the next edge
    @(negedge clk);
    m_in = vt[3].m; n_in = vt[3].n; matrices_in = vt[3].bus;
    #1;
    check_all("latency_hold", vt[1].em, vt[1].en, vt[1].ev, vt[1].eout);
    @(posedge clk); #1;
    check_all("latency_update", vt[3].em, vt[3].en, vt[3].ev, vt[3].eout);
`else
    // Combinational build: change inputs between edges and see them settle without a clock
    @(posedge clk); #2;
    m_in = vt[3].m; n_in = vt[3].n; matrices_in = vt[3].bus;
    #1;
    check_all("comb_no_edge", vt[3].em, vt[3].en, vt[3].ev, vt[3].eout);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
